// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide unit owning the HI/LO register pair.
// One 34-bit adder is shared by the shift-add multiplier and the restoring divider.
module muldiv_unit #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [Width-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] hi,
    output logic [Width-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_acc;
    logic [31:0] r_shf;
    logic [31:0] r_opnd;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_is_div;
    logic [32:0] w_rem_shift;
    logic [33:0] w_add_a;
    logic [33:0] w_add_b;
    logic [33:0] w_sum;
    logic [32:0] w_mul_sum;
    logic [31:0] w_acc_nxt;
    logic [31:0] w_shf_nxt;
    logic [63:0] w_prod_fix;
    logic [31:0] w_hi_fix;
    logic [31:0] w_lo_fix;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return (~v) + 64'd1;
    endfunction

    // One iteration step: add for multiply, trial subtract for divide.
    always_comb begin
        w_is_div    = r_op[1];
        w_rem_shift = {r_acc, r_shf[31]};
        if (w_is_div) begin
            w_add_a = {1'b0, w_rem_shift};
            w_add_b = ~{2'b00, r_opnd};
        end else begin
            w_add_a = {2'b00, r_acc};
            w_add_b = {2'b00, r_opnd};
        end
        w_sum     = w_add_a + w_add_b + {33'd0, w_is_div};
        w_mul_sum = {1'b0, r_acc};
        w_acc_nxt = r_acc;
        w_shf_nxt = r_shf;
        if (w_is_div) begin
            // bit 33 clear means the trial difference is non-negative
            if (!w_sum[33]) begin
                w_acc_nxt = w_sum[31:0];
                w_shf_nxt = {r_shf[30:0], 1'b1};
            end else begin
                w_acc_nxt = w_rem_shift[31:0];
                w_shf_nxt = {r_shf[30:0], 1'b0};
            end
        end else begin
            if (r_shf[0]) begin
                w_mul_sum = w_sum[32:0];
            end else begin
                w_mul_sum = {1'b0, r_acc};
            end
            w_acc_nxt = w_mul_sum[32:1];
            w_shf_nxt = {w_mul_sum[0], r_shf[31:1]};
        end
    end

    // Sign post-correction of the finished magnitude result.
    always_comb begin
        w_prod_fix = {r_acc, r_shf};
        w_hi_fix   = r_acc;
        w_lo_fix   = r_shf;
        if (r_op[1]) begin
            if (r_div0) begin
                w_lo_fix = 32'hFFFF_FFFF;
            end else if (r_neg_q) begin
                w_lo_fix = neg32(r_shf);
            end else begin
                w_lo_fix = r_shf;
            end
            if (r_neg_r) begin
                w_hi_fix = neg32(r_acc);
            end else begin
                w_hi_fix = r_acc;
            end
        end else begin
            if (r_neg_q) begin
                w_prod_fix = neg64({r_acc, r_shf});
            end else begin
                w_prod_fix = {r_acc, r_shf};
            end
            w_hi_fix = w_prod_fix[63:32];
            w_lo_fix = w_prod_fix[31:0];
        end
    end

    // Sequencer, datapath registers and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_op    <= 2'b00;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_acc   <= 32'd0;
            r_shf   <= 32'd0;
            r_opnd  <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_PREP;
                        r_op    <= op;
                        r_shf   <= a;
                        r_opnd  <= b;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (mthi) begin
                            r_hi <= wdata;
                        end
                        if (mtlo) begin
                            r_lo <= wdata;
                        end
                    end
                end
                S_PREP: begin
                    r_neg_q <= r_op[0] & (r_shf[31] ^ r_opnd[31]);
                    r_neg_r <= r_op[0] & r_shf[31];
                    r_div0  <= (r_opnd == 32'd0);
                    if (r_op[0] && r_shf[31]) begin
                        r_shf <= neg32(r_shf);
                    end
                    if (r_op[0] && r_opnd[31]) begin
                        r_opnd <= neg32(r_opnd);
                    end
                    r_acc   <= 32'd0;
                    r_cnt   <= 5'd0;
                    r_state <= S_CALC;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
                S_CALC: begin
                    r_acc  <= w_acc_nxt;
                    r_shf  <= w_shf_nxt;
                    r_cnt  <= r_cnt + 5'd1;
                    r_busy <= 1'b1;
                    r_done <= 1'b0;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_hi_fix;
                    r_lo    <= w_lo_fix;
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO are queued at start and
// checked against the DUT on the done cycle, with busy/done checked every cycle.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        s_rst;
    logic        s_start;
    logic [1:0]  s_op;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic        s_mthi;
    logic        s_mtlo;
    logic [31:0] s_wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t        sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_vec;
    int          n_err;

    muldiv_unit #(.Width(32)) dut (
        .clk   (clk),
        .rst   (s_rst),
        .start (s_start),
        .op    (s_op),
        .a     (s_a),
        .b     (s_b),
        .mthi  (s_mthi),
        .mtlo  (s_mtlo),
        .wdata (s_wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: wide integer arithmetic, MIPS divide-by-zero convention.
    function automatic logic [63:0] ref_model(input logic [1:0] op_v, input logic [31:0] av,
                                              input logic [31:0] bv);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        p = 64'd0;
        case (op_v)
            2'b00: p = {32'd0, av} * {32'd0, bv};
            2'b01: begin
                sa = longint'($signed(av));
                sb = longint'($signed(bv));
                p  = sa * sb;
            end
            2'b10: begin
                if (bv == 32'd0) p = {av, 32'hFFFF_FFFF};
                else p = {av % bv, av / bv};
            end
            2'b11: begin
                if (bv == 32'd0) begin
                    p = {av, 32'hFFFF_FFFF};
                end else begin
                    sa = longint'($signed(av));
                    sb = longint'($signed(bv));
                    q  = sa / sb;
                    r  = sa % sb;
                    p  = {r[31:0], q[31:0]};
                end
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    task automatic launch(input logic [1:0] op_v, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] hi_e, input logic [31:0] lo_e);
        exp_t e;
        s_start = 1'b1;
        s_op    = op_v;
        s_a     = av;
        s_b     = bv;
        e.hi    = hi_e;
        e.lo    = lo_e;
        sb_q.push_back(e);
    endtask

    // Follows cycles 1..35 after a start; optionally injects ignored stimulus at inj_k.
    task automatic track(input string tag, input int inj_k);
        exp_t e;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            s_start = 1'b0;
            s_mthi  = 1'b0;
            s_mtlo  = 1'b0;
            chk({tag, "_busy"}, {31'd0, busy}, (k <= 34) ? 32'd1 : 32'd0);
            chk({tag, "_done"}, {31'd0, done}, (k == 35) ? 32'd1 : 32'd0);
            if (k == 17) begin
                chk({tag, "_hi_hold"}, hi, m_hi);
                chk({tag, "_lo_hold"}, lo, m_lo);
            end
            if (k == inj_k) begin
                s_start = 1'b1;
                s_op    = 2'b00;
                s_a     = 32'h1111_2222;
                s_b     = 32'h3333_4444;
                s_mthi  = 1'b1;
                s_wdata = 32'h0000_1234;
            end
            if (k == 35) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk({tag, "_hi"}, hi, e.hi);
                    chk({tag, "_lo"}, lo, e.lo);
                    m_hi = e.hi;
                    m_lo = e.lo;
                end else begin
                    chk({tag, "_sb_size"}, 32'(sb_q.size()), 32'd1);
                end
            end
        end
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    endtask

    logic [63:0] rv;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    logic        saw_done;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        s_rst   = 1'b0;
        s_start = 1'b1;
        s_op    = 2'b00;
        s_a     = 32'd5;
        s_b     = 32'd6;
        s_mthi  = 1'b1;
        s_mtlo  = 1'b1;
        s_wdata = 32'hDEAD_BEEF;

        // Reset with start/mthi/mtlo held high: reset must win
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        s_rst   = 1'b1;
        s_start = 1'b0;
        s_mthi  = 1'b0;
        s_mtlo  = 1'b0;

        @(negedge clk);
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        track("multu_max", 0);
        idle_chk("multu_max");

        @(negedge clk);
        launch(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        track("mult_neg", 0);
        idle_chk("mult_neg");

        @(negedge clk);
        launch(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        track("mult_min", 0);
        idle_chk("mult_min");

        @(negedge clk);
        launch(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        track("div_neg", 0);
        idle_chk("div_neg");

        @(negedge clk);
        launch(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
        track("divu_100_7", 0);
        idle_chk("divu_100_7");

        @(negedge clk);
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        track("div_ovf", 0);
        idle_chk("div_ovf");

        @(negedge clk);
        launch(2'b10, 32'h0000_0064, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        track("divu_zero", 0);
        idle_chk("divu_zero");

        @(negedge clk);
        launch(2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        track("div_zero", 0);
        idle_chk("div_zero");

        // start + mthi during CALC must be ignored
        @(negedge clk);
        launch(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
        track("divu_inj", 10);
        idle_chk("divu_inj");

        s_mtlo  = 1'b1;
        s_wdata = 32'h0000_ABCD;
        @(negedge clk);
        s_mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_ABCD);
        chk("mtlo_hi", hi, m_hi);
        m_lo = 32'h0000_ABCD;

        s_mthi  = 1'b1;
        s_mtlo  = 1'b1;
        s_wdata = 32'h5A5A_0F0F;
        @(negedge clk);
        s_mthi = 1'b0;
        s_mtlo = 1'b0;
        chk("mtboth_hi", hi, 32'h5A5A_0F0F);
        chk("mtboth_lo", lo, 32'h5A5A_0F0F);
        m_hi = 32'h5A5A_0F0F;
        m_lo = 32'h5A5A_0F0F;

        // mthi coincident with an accepted start is dropped; second op starts in DONE
        @(negedge clk);
        launch(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        s_mthi  = 1'b1;
        s_wdata = 32'h0000_0077;
        track("b2b_first", 0);
        launch(2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
        track("b2b_second", 0);
        idle_chk("b2b_second");

        for (int i = 0; i < 4; i++) begin
            ra  = $urandom;
            rb  = (i >= 2) ? ($urandom & 32'h0000_FFFF) : $urandom;
            rop = i[1:0];
            rv  = ref_model(rop, ra, rb);
            @(negedge clk);
            launch(rop, ra, rb, rv[63:32], rv[31:0]);
            track($sformatf("rand%0d", i), 0);
            idle_chk($sformatf("rand%0d", i));
        end

        // Reset in cycle 10 of a MULT discards it
        @(negedge clk);
        launch(2'b01, 32'd5, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFE2);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (k == 10) s_rst = 1'b0;
        end
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        s_rst = 1'b1;
        sb_q.delete();
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        chk("midrst_no_done", {31'd0, saw_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
